dual_issue_scheduler: RTL and testbench
=======================================

# dual_issue_scheduler

Issue-slot scheduler for the two-wide in-order pipeline. It sits between the IF/ID pair register and ID/EX. Each cycle it decides whether the decoded pair issues together, issues split over two cycles, or has slot 2 squashed. When a pair is split, it sequences the split by holding fetch and IF/ID for one cycle. The aggregated load-use/jr stall and the branch-recovery flush from the hazard detection unit override all scheduling decisions.

## Interface
Parameters:
- CNT_W, 16, width of the saturating split-event counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces state PAIR and clears the counter.
- validD1, validD2  in  1  slot 1 / slot 2 hold a real instruction in decode.
- regWriteD1  in  1  slot 1 writes a register.
- writeRegD1  in  5  slot 1 destination register.
- rsD2, rtD2  in  5  slot 2 source registers.
- usesRtD2  in  1  slot 2 reads rt as a source (not I-type destination).
- memAccessD1, memAccessD2  in  1  slot uses the single data-memory port (load or store).
- branchD1, branchD2  in  1  slot is a conditional branch (single predictor-update port).
- predTakenD1  in  1  slot 1 is a jump, or a branch predicted taken.
- stallIn  in  1  OR of all hazard-unit stall outputs (load-use, jr).
- flushIn  in  1  IF/ID flush from the hazard unit (pcSrc or mispredict).
- issue1, issue2  out  1  write slot 1 / slot 2 into ID/EX this cycle; 0 inserts a bubble.
- holdFetch  out  1  freeze PC and IF/ID this cycle.
- splitActive  out  1  state is SECOND.
- splitCount  out  CNT_W  number of split events since reset, saturating.

## Operation
Conflict is the OR of three conditions, evaluated only when validD1 & validD2 & !predTakenD1:
- RAW: regWriteD1 & writeRegD1≠0 & (writeRegD1==rsD2 | (usesRtD2 & writeRegD1==rtD2)).
- Memory port: memAccessD1 & memAccessD2.
- Branch port: branchD1 & branchD2.

Kill: validD1 & predTakenD1 means slot 2 is wrong-path. In that case issue2=0 and no split occurs.

FSM states are PAIR (reset state) and SECOND. Priority within each state is flushIn > stallIn > normal.

PAIR:
- flushIn: issue1=issue2=0, holdFetch=0, stay in PAIR.
- stallIn: issue1=issue2=0, holdFetch=1, stay in PAIR.
- Conflict: issue1=1, issue2=0, holdFetch=1, go to SECOND, increment splitCount.
- Otherwise: issue1=validD1, issue2=validD2 & !kill, holdFetch=0.

SECOND (slot 1 has already issued; IF/ID still holds the pair):
- flushIn: issue1=issue2=0, holdFetch=0, go to PAIR. The pending slot 2 is discarded.
- stallIn: issue1=issue2=0, holdFetch=1, stay in SECOND.
- Otherwise: issue1=0, issue2=validD2, holdFetch=0, go to PAIR. Conflict terms are ignored in this state.

Other rules:
- splitCount saturates at all-ones and never wraps.
- All outputs are 0 when both valid inputs are 0, except holdFetch under stallIn.

## Timing
- Outputs issue1, issue2 and holdFetch are combinational (Mealy) from the state and same-cycle inputs. No added latency.
- splitActive and splitCount are registered.
- A split pair occupies 2 cycles in decode; a non-split pair occupies 1. Each stall cycle adds 1 cycle in either state.
- Reset is asynchronous. On assertion: state=PAIR, splitCount=0, splitActive=0, issue1=issue2=holdFetch=0 while reset is high.
- If reset is asserted while in SECOND, the pending slot 2 is dropped.
- flushIn in the same cycle as a conflict: the flush wins. Nothing issues, no transition, no count.
- stallIn in the same cycle as a conflict in PAIR: the stall wins. The conflict is re-evaluated next cycle.
- Back-to-back conflicting pairs: PAIR→SECOND→PAIR→SECOND. There is never an idle cycle between them; splitCount increments on each PAIR→SECOND edge.

## Test plan
- Independent pair: validD1=validD2=1, writeRegD1=5, rsD2=6, rtD2=7 → issue1=issue2=1, holdFetch=0, state stays PAIR, splitCount=0.
- RAW split: regWriteD1=1, writeRegD1=8, rsD2=8 → cycle 0: issue1=1, issue2=0, holdFetch=1. Cycle 1: splitActive=1, issue1=0, issue2=1, holdFetch=0. splitCount=1.
- $zero and kill cases:
  - writeRegD1=0, rsD2=0 with a memory conflict absent → pair issues together.
  - predTakenD1=1 with conflicting operands → issue1=1, issue2=0, no split, splitCount unchanged.
- Stall inside split: enter SECOND via memAccessD1=memAccessD2=1, then stallIn=1 for 2 cycles → issue1=issue2=0 and holdFetch=1 for both cycles. Third cycle: issue2=1, return to PAIR.
- Flush and reset in SECOND:
  - flushIn=1 while in SECOND → issue2=0, holdFetch=0, next state PAIR.
  - Separately, assert reset in SECOND → splitActive drops immediately (asynchronously) and splitCount=0.
- Saturation: CNT_W=2, run 5 back-to-back branchD1=branchD2=1 pairs → splitCount reads 1,2,3,3,3.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// Issue-slot scheduler for the two-wide in-order pipeline.
// Decides pair / split / squash per decode cycle and sequences splits.
module dual_issue_scheduler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validD1,
    input  logic             validD2,
    input  logic             regWriteD1,
    input  logic [4:0]       writeRegD1,
    input  logic [4:0]       rsD2,
    input  logic [4:0]       rtD2,
    input  logic             usesRtD2,
    input  logic             memAccessD1,
    input  logic             memAccessD2,
    input  logic             branchD1,
    input  logic             branchD2,
    input  logic             predTakenD1,
    input  logic             stallIn,
    input  logic             flushIn,
    output logic             issue1,
    output logic             issue2,
    output logic             holdFetch,
    output logic             splitActive,
    output logic [CNT_W-1:0] splitCount
);

    typedef enum logic {
        PAIR   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic raw_hit;
    logic mem_hit;
    logic br_hit;
    logic conflict;
    logic kill;
    logic issue1_c;
    logic issue2_c;
    logic hold_c;
    logic split_evt;

    // $zero is never a real dependency, so writeRegD1==0 cannot raise RAW.
    always_comb begin
        raw_hit = regWriteD1 && (writeRegD1 != 5'd0) &&
                  ((writeRegD1 == rsD2) ||
                   (usesRtD2 && (writeRegD1 == rtD2)));
        mem_hit = memAccessD1 && memAccessD2;
        br_hit  = branchD1 && branchD2;
        kill    = validD1 && predTakenD1;
        conflict = validD1 && validD2 && !predTakenD1 &&
                   (raw_hit || mem_hit || br_hit);
    end

    always_comb begin
        state_d   = state_q;
        issue1_c  = 1'b0;
        issue2_c  = 1'b0;
        hold_c    = 1'b0;
        split_evt = 1'b0;
        unique case (state_q)
            PAIR: begin
                if (flushIn) begin
                    state_d = PAIR;
                end else if (stallIn) begin
                    hold_c = 1'b1;
                end else if (conflict) begin
                    issue1_c  = 1'b1;
                    hold_c    = 1'b1;
                    state_d   = SECOND;
                    split_evt = 1'b1;
                end else begin
                    issue1_c = validD1;
                    issue2_c = validD2 && !kill;
                end
            end
            SECOND: begin
                if (flushIn) begin
                    state_d = PAIR;
                end else if (stallIn) begin
                    hold_c = 1'b1;
                end else begin
                    issue2_c = validD2;
                    state_d  = PAIR;
                end
            end
            default: begin
                state_d = PAIR;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (split_evt && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PAIR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mealy outputs are forced low while reset is held.
    assign issue1      = issue1_c && !reset;
    assign issue2      = issue2_c && !reset;
    assign holdFetch   = hold_c && !reset;
    assign splitActive = (state_q == SECOND);
    assign splitCount  = cnt_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler (CNT_W=2 to reach saturation).
// Expected {issue1,issue2,holdFetch,splitActive,splitCount} per cycle.
module tb_dual_issue_scheduler;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             validD1, validD2;
    logic             regWriteD1;
    logic [4:0]       writeRegD1, rsD2, rtD2;
    logic             usesRtD2;
    logic             memAccessD1, memAccessD2;
    logic             branchD1, branchD2;
    logic             predTakenD1;
    logic             stallIn, flushIn;
    logic             issue1, issue2, holdFetch, splitActive;
    logic [CNT_W-1:0] splitCount;

    typedef struct {
        string      tag;
        logic [5:0] e;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    dual_issue_scheduler #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .validD1     (validD1),
        .validD2     (validD2),
        .regWriteD1  (regWriteD1),
        .writeRegD1  (writeRegD1),
        .rsD2        (rsD2),
        .rtD2        (rtD2),
        .usesRtD2    (usesRtD2),
        .memAccessD1 (memAccessD1),
        .memAccessD2 (memAccessD2),
        .branchD1    (branchD1),
        .branchD2    (branchD2),
        .predTakenD1 (predTakenD1),
        .stallIn     (stallIn),
        .flushIn     (flushIn),
        .issue1      (issue1),
        .issue2      (issue2),
        .holdFetch   (holdFetch),
        .splitActive (splitActive),
        .splitCount  (splitCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] obs,
                       input logic [5:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (i1 i2 hold sa cnt)",
                     tag, obs, exp);
        end
    endtask

    // Pop one expectation per cycle, sampled mid low-phase.
    always @(negedge clk) begin
        sb_t it;
        #2;
        if (sb.size() > 0) begin
            it = sb.pop_front();
            chk(it.tag, {issue1, issue2, holdFetch, splitActive,
                         splitCount}, it.e);
        end
    end

    task automatic clr();
        validD1 = 0; validD2 = 0; regWriteD1 = 0;
        writeRegD1 = 0; rsD2 = 0; rtD2 = 0; usesRtD2 = 0;
        memAccessD1 = 0; memAccessD2 = 0;
        branchD1 = 0; branchD2 = 0; predTakenD1 = 0;
        stallIn = 0; flushIn = 0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic expect_v(input string tag, input logic [5:0] e);
        sb_t it;
        it.tag = tag;
        it.e   = e;
        sb.push_back(it);
    endtask

    task automatic mem_pair();
        clr();
        validD1 = 1; validD2 = 1;
        memAccessD1 = 1; memAccessD2 = 1;
    endtask

    task automatic do_reset();
        nxt(); clr(); reset = 1;
        expect_v("rst", 6'b000000);
        nxt(); clr(); reset = 0;
        expect_v("rst_rel", 6'b000000);
    endtask

    initial begin
        reset = 1;
        clr();
        // Reset gates outputs even with a live pair and stall present.
        nxt(); validD1 = 1; validD2 = 1; stallIn = 1;
        expect_v("rst_out", 6'b000000);
        nxt(); clr(); reset = 0;
        expect_v("idle", 6'b000000);

        nxt(); clr();
        validD1 = 1; validD2 = 1; regWriteD1 = 1;
        writeRegD1 = 5; rsD2 = 6; rtD2 = 7; usesRtD2 = 1;
        expect_v("indep", 6'b110000);
        nxt(); clr();
        expect_v("indep_after", 6'b000000);

        nxt(); clr();
        validD1 = 1; validD2 = 1; regWriteD1 = 1;
        writeRegD1 = 8; rsD2 = 8;
        expect_v("raw_c0", 6'b101000);
        nxt();
        expect_v("raw_c1", 6'b010101);
        nxt(); clr();
        expect_v("raw_done", 6'b000001);

        nxt(); clr();
        validD1 = 1; validD2 = 1; regWriteD1 = 1; usesRtD2 = 1;
        expect_v("zero_reg", 6'b110001);

        nxt(); clr();
        validD1 = 1; validD2 = 1; predTakenD1 = 1; regWriteD1 = 1;
        writeRegD1 = 8; rsD2 = 8; memAccessD1 = 1; memAccessD2 = 1;
        expect_v("kill", 6'b100001);
        nxt(); clr();
        expect_v("kill_after", 6'b000001);

        nxt(); mem_pair();
        expect_v("st_split", 6'b101001);
        nxt(); stallIn = 1;
        expect_v("st_sec1", 6'b001110);
        nxt();
        expect_v("st_sec2", 6'b001110);
        nxt(); stallIn = 0;
        expect_v("st_sec3", 6'b010110);
        nxt(); clr();
        expect_v("st_done", 6'b000010);

        nxt(); mem_pair();
        expect_v("fl_split", 6'b101010);
        nxt(); flushIn = 1;
        expect_v("fl_sec", 6'b000111);
        nxt(); clr();
        expect_v("fl_pair", 6'b000011);

        // Async reset while in SECOND drops the pending slot 2.
        nxt(); mem_pair();
        expect_v("rs_split", 6'b101011);
        nxt(); stallIn = 1;
        expect_v("rs_sec", 6'b001111);
        nxt(); reset = 1;
        expect_v("rs_async", 6'b000000);
        nxt(); clr(); reset = 0;
        expect_v("rs_rel", 6'b000000);

        nxt(); mem_pair(); flushIn = 1;
        expect_v("flush_conf", 6'b000000);
        nxt(); clr();
        expect_v("flush_conf2", 6'b000000);

        nxt(); mem_pair(); stallIn = 1;
        expect_v("stall_conf", 6'b001000);
        nxt(); stallIn = 0;
        expect_v("stall_conf2", 6'b101000);
        nxt();
        expect_v("stall_conf3", 6'b010101);

        do_reset();
        for (int k = 0; k < 5; k++) begin
            logic [1:0] pre;
            logic [1:0] post;
            pre  = (k < 3) ? 2'(k) : 2'd3;
            post = (k < 2) ? 2'(k + 1) : 2'd3;
            nxt(); clr();
            validD1 = 1; validD2 = 1; branchD1 = 1; branchD2 = 1;
            expect_v($sformatf("sat%0d_a", k), {4'b1010, pre});
            nxt();
            expect_v($sformatf("sat%0d_b", k), {4'b0101, post});
        end
        nxt(); clr();
        expect_v("sat_end", 6'b000011);

        nxt(); nxt();
        chk("sb_drain", 6'(sb.size()), 6'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
